// File: rtl/serial_adder_nb.sv
// Bit-serial ripple adder: one full-add cell and a carry flop,
// LSB first, n+1 cycles per operation including the DONE cycle.
module serial_adder_nb #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         Cin,
    output logic [n-1:0] Result,
    output logic         Cout,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    state_t         state_q, state_d;
    logic [n-1:0]   a_sh_q, a_sh_d;
    logic [n-1:0]   b_sh_q, b_sh_d;
    logic [n-1:0]   sum_q, sum_d;
    logic [n-1:0]   result_q, result_d;
    logic           cout_q, cout_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           s_bit;
    logic           c_nxt;
    logic [n-1:0]   sum_nxt;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_d    = sum_q;
        result_d = result_q;
        cout_d   = cout_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;

        s_bit = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        c_nxt = (a_sh_q[0] & b_sh_q[0]) |
                (a_sh_q[0] & carry_q) |
                (b_sh_q[0] & carry_q);
        // New sum bit enters from the MSB so bit 0 ends at the LSB.
        sum_nxt        = sum_q >> 1;
        sum_nxt[n-1]   = s_bit;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = Cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = sum_nxt;
                carry_d = c_nxt;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    result_d = sum_nxt;
                    cout_d   = c_nxt;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Result = result_q;
    assign Cout   = cout_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);

endmodule

// File: doc/serial_adder_nb.md
SERIAL_ADDER_NB -- requirements
Module: serial_adder_nb

Interface
REQ-001 The module SHALL have parameter n, default 4, giving the operand width in bits; legal values are n >= 1.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and is an asynchronous, active-low reset.
REQ-004 Port start SHALL be an input, 1 bit wide, and requests an operation; it is sampled on the rising edge.
REQ-005 Port a SHALL be an input, n bits wide, and is the first operand, sampled only when start is accepted.
REQ-006 Port b SHALL be an input, n bits wide, and is the second operand, sampled only when start is accepted.
REQ-007 Port Cin SHALL be an input, 1 bit wide, and is the carry-in, sampled only when start is accepted.
REQ-008 Port Result SHALL be an output, n bits wide, and holds the registered sum of the last completed operation.
REQ-009 Port Cout SHALL be an output, 1 bit wide, and holds the registered carry-out of the last completed operation.
REQ-010 Port busy SHALL be an output, 1 bit wide, and is high while an operation is in progress.
REQ-011 Port done SHALL be an output, 1 bit wide, and is a one-cycle pulse marking that Result and Cout were just updated.

Function
REQ-012 The block SHALL compute {Cout, Result} = a + b + Cin modulo 2^(n+1), one bit per clock, LSB first, using a single 1-bit full-add cell and a carry flip-flop.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL be accepted, which means: latch a and b into internal shift registers, load the carry flip-flop with Cin, clear the bit counter, and go to RUN.
REQ-015 In IDLE with start=0, the FSM SHALL stay in IDLE; in DONE with start=0, it SHALL go to IDLE.
REQ-016 In RUN, each edge SHALL process bit i as follows: sum_i = a_i ^ b_i ^ c; c <= majority(a_i, b_i, c); shift sum_i into the internal sum register from the MSB side; shift the operand registers right; increment the counter.
REQ-017 The bit counter SHALL be $clog2(n+1) bits wide; on the edge that processes bit n-1, the FSM SHALL go to DONE.
REQ-018 On that same edge, Result SHALL load the complete internal sum and Cout SHALL load the final carry.
REQ-019 Latency: if start is accepted at edge E0, then Result, Cout and done=1 SHALL become visible immediately after edge E0+n.
REQ-020 Throughput: with start held high, a new operation SHALL begin at the DONE-state edge, giving one result every n+1 cycles.
REQ-021 busy SHALL equal (state == RUN), and done SHALL equal (state == DONE); both are decoded from registered state.
REQ-022 While in RUN, start SHALL be ignored, and a, b and Cin SHALL have no effect on the operation in flight.
REQ-023 Result and Cout SHALL keep their previous values throughout RUN and IDLE; they SHALL change only on the completion edge.
REQ-024 For n=1, RUN SHALL last exactly one cycle.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force: state=IDLE, Result=0, Cout=0, busy=0, done=0, counter=0, carry=0, and all internal shift registers=0.
REQ-026 A reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow, and Result and Cout SHALL read 0.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 n=4, a=3, b=5, Cin=0, start pulsed at E0 -> busy=1 for edges E0..E0+n-1, done=1 after E0+4, Result=8, Cout=0.
REQ-029 n=4, a=15, b=1, Cin=0 -> Result=0, Cout=1; n=4, a=15, b=15, Cin=1 -> Result=15, Cout=1.
REQ-030 n=4, second start with a=1, b=1 at E0+2 during RUN of 3+5 -> the second start is ignored, Result=8 at E0+4, and no extra done pulse occurs.
REQ-031 n=4, rst_n pulsed low after E0+2 during 7+7 -> outputs are 0 immediately, and no done pulse occurs afterward.
REQ-032 n=4, start held high with a=2, b=3, Cin=1 -> done pulses every 5 cycles, Result=6, Cout=0 each time.
REQ-033 n=8, a=200, b=100, Cin=0 -> done after E0+8, Result=44, Cout=1; a bench SHALL also sweep all operand pairs for n=4 against a+b+Cin.
